// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared FSM/owner types and bus width defaults for the memory port arbiter
package cpu_mem_pkg;
    typedef enum logic [1:0] {IDLE, ACC_IF, ACC_MEM, DONE} arb_state_t;
    typedef enum logic {OWN_IF, OWN_MEM} arb_owner_t;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts cycles a bus access is outstanding and raises a sticky err_o at TIMEOUT
module mem_arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run,
    input  logic clr,
    output logic err_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt   <= '0;
            err_o <= 1'b0;
        end else begin
            cnt   <= clr ? '0 : (run && cnt != CW'(TIMEOUT)) ? cnt + CW'(1) : cnt;
            err_o <= err_o | (run && !clr && cnt == CW'(TIMEOUT - 1));
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/ack memory between IF and MEM, MEM first with an IF starvation guard
// ARB_PERF_CNT_EN adds per-port stall cycle counters.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int MEM_BURST_MAX = 4,
    parameter int TIMEOUT       = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ready_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ready_o,
    output logic              ram_req_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    input  logic              ram_ack_i,
    output logic              err_o
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       if_stall_cnt_o,
    output logic [31:0]       mem_stall_cnt_o
`endif
);
    localparam int BW = $clog2(MEM_BURST_MAX + 1);
    arb_state_t state, state_d;
    arb_owner_t owner;
    logic [BW-1:0] burst_cnt;
    logic [DATA_W-1:0] rdata_q;
    logic drop, grant_mem, grant_if, in_acc;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_d;
    end
    always_comb begin
        in_acc      = state == ACC_IF || state == ACC_MEM;
        grant_mem   = state == IDLE && mem_req_i && !(burst_cnt == BW'(MEM_BURST_MAX) && if_req_i);
        grant_if    = state == IDLE && !grant_mem && if_req_i && !if_flush_i;
        state_d     = grant_mem ? ACC_MEM : grant_if ? ACC_IF : (in_acc && ram_ack_i) ? DONE :
                      state == DONE ? IDLE : state;
        ram_req_o   = in_acc;
        if_ready_o  = state == DONE && owner == OWN_IF && !drop && !if_flush_i;
        mem_ready_o = state == DONE && owner == OWN_MEM;
    end
    // A flushed fetch still finishes on the bus; drop only hides its completion from IF.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner       <= OWN_IF;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            drop        <= 1'b0;
            rdata_q     <= '0;
            burst_cnt   <= '0;
        end else begin
            if (grant_mem || grant_if) begin
                owner       <= grant_mem ? OWN_MEM : OWN_IF;
                ram_we_o    <= grant_mem && mem_we_i;
                ram_addr_o  <= grant_mem ? mem_addr_i : if_addr_i;
                ram_wdata_o <= grant_mem ? mem_wdata_i : '0;
                drop        <= 1'b0;
            end else if (state == ACC_IF && if_flush_i) begin
                drop <= 1'b1;
            end
            if (in_acc && ram_ack_i) rdata_q <= ram_rdata_i;
            burst_cnt <= (!if_req_i || grant_if) ? '0 :
                         (grant_mem && burst_cnt != BW'(MEM_BURST_MAX)) ? burst_cnt + BW'(1) : burst_cnt;
        end
    end
    assign if_data_o   = rdata_q;
    assign mem_rdata_o = rdata_q;
    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .run  (in_acc),
        .clr  (ram_ack_i),
        .err_o(err_o)
    );
`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if_stall_cnt_o  <= '0;
            mem_stall_cnt_o <= '0;
        end else begin
            if_stall_cnt_o  <= if_stall_cnt_o + 32'(if_req_i && !if_ready_o);
            mem_stall_cnt_o <= mem_stall_cnt_o + 32'(mem_req_i && !mem_ready_o);
        end
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with queued expectations checked by a negedge monitor
module tb_mem_port_arbiter;
    typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} ram_t;
    typedef struct packed {logic chk; logic [31:0] d;} rd_t;
    logic clk_i = 1'b0, rst_i = 1'b1;
    logic if_req_i = 0, if_flush_i = 0, mem_req_i = 0, mem_we_i = 0, ram_ack_i = 0;
    logic [31:0] if_addr_i = 0, mem_addr_i = 0, mem_wdata_i = 0, ram_rdata_i = 0;
    logic [31:0] if_data_o, mem_rdata_o, ram_addr_o, ram_wdata_o;
    logic if_ready_o, mem_ready_o, ram_req_o, ram_we_o, err_o;
    int tests = 0, fails = 0, ack_delay = 1, wait_cnt = 0, lat;
    logic hold = 1'b0;
    ram_t exp_ram[$];
    rd_t exp_if[$], exp_mem[$];

    mem_port_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_data_o(if_data_o), .if_ready_o(if_ready_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ready_o(mem_ready_o),
        .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .ram_ack_i(ram_ack_i),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor plus memory model: pops expectations on ready pulses and on each ack it issues.
    always @(negedge clk_i) begin
        rd_t r;
        ram_t e;
        if (!rst_i) begin
            if (if_ready_o) begin
                if (exp_if.size() == 0) chk("if_ready_unexpected", 1, 0);
                else begin r = exp_if.pop_front(); if (r.chk) chk("if_data", if_data_o, r.d); end
            end
            if (mem_ready_o) begin
                if (exp_mem.size() == 0) chk("mem_ready_unexpected", 1, 0);
                else begin r = exp_mem.pop_front(); if (r.chk) chk("mem_rdata", mem_rdata_o, r.d); end
            end
        end
        if (rst_i || !ram_req_o) begin
            ram_ack_i = 1'b0;
            wait_cnt  = 0;
        end else if (!hold) begin
            if (wait_cnt >= ack_delay) begin
                ram_ack_i   = 1'b1;
                ram_rdata_i = ram_addr_o ^ 32'hC0DE_0000;
                wait_cnt    = 0;
                if (exp_ram.size() == 0) chk("ram_unexpected", 1, 0);
                else begin
                    e = exp_ram.pop_front();
                    chk("ram_we", 32'(ram_we_o), 32'(e.we));
                    chk("ram_addr", ram_addr_o, e.addr);
                    if (e.we) chk("ram_wdata", ram_wdata_o, e.wdata);
                end
            end else wait_cnt++;
        end
    end

    task automatic if_access(input logic [31:0] a, output int n);
        if_req_i = 1'b1; if_addr_i = a; n = 0;
        do begin @(negedge clk_i); n++; end while (!if_ready_o && n < 200);
        if (!if_ready_o) chk("if_ready_timeout", 0, 1);
        @(posedge clk_i); #1;
        if_req_i = 1'b0;
    endtask

    task automatic mem_access(input logic we, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = a; mem_wdata_i = d;
        do begin @(negedge clk_i); n++; end while (!mem_ready_o && n < 200);
        if (!mem_ready_o) chk("mem_ready_timeout", 0, 1);
        @(posedge clk_i); #1;
        mem_req_i = 1'b0; mem_we_i = 1'b0;
    endtask

    task automatic wait_ram_req();
        int n = 0;
        do begin @(negedge clk_i); n++; end while (!ram_req_o && n < 50);
        if (!ram_req_o) chk("ram_req_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        #12;
        chk("rst_ram_req", 32'(ram_req_o), 0);
        chk("rst_ram_addr", ram_addr_o, 0);
        chk("rst_if_ready", 32'(if_ready_o), 0);
        chk("rst_mem_ready", 32'(mem_ready_o), 0);
        chk("rst_err", 32'(err_o), 0);
        @(posedge clk_i); #1; rst_i = 1'b0;
        @(posedge clk_i); #1;
        // IF only, ack one cycle after request
        ack_delay = 1;
        exp_ram.push_back('{1'b0, 32'h0, 32'h0});
        exp_if.push_back('{1'b1, 32'hC0DE_0000});
        if_access(32'h0, lat);
        chk("if_latency_ack1", 32'(lat), 4);
        // IF only, immediate ack gives minimum latency
        ack_delay = 0;
        exp_ram.push_back('{1'b0, 32'h8, 32'h0});
        exp_if.push_back('{1'b1, 32'hC0DE_0008});
        if_access(32'h8, lat);
        chk("if_latency_ack0", 32'(lat), 3);
        // Contention: MEM first, then IF
        exp_ram.push_back('{1'b0, 32'h40, 32'h0});
        exp_ram.push_back('{1'b0, 32'h44, 32'h0});
        exp_mem.push_back('{1'b1, 32'hC0DE_0040});
        exp_if.push_back('{1'b1, 32'hC0DE_0044});
        fork
            mem_access(1'b0, 32'h40, 32'h0);
            if_access(32'h44, lat);
        join
        // Starvation guard: four MEM grants, then IF, then MEM resumes
        for (int k = 0; k < 4; k++) exp_ram.push_back('{1'b0, 32'h100 + 32'(4 * k), 32'h0});
        exp_ram.push_back('{1'b0, 32'h200, 32'h0});
        for (int k = 4; k < 6; k++) exp_ram.push_back('{1'b0, 32'h100 + 32'(4 * k), 32'h0});
        for (int k = 0; k < 6; k++) exp_mem.push_back('{1'b1, 32'hC0DE_0100 + 32'(4 * k)});
        exp_if.push_back('{1'b1, 32'hC0DE_0200});
        @(posedge clk_i); #1;
        fork
            for (int k = 0; k < 6; k++) mem_access(1'b0, 32'h100 + 32'(4 * k), 32'h0);
            if_access(32'h200, lat);
        join
        // Flush during ACC_IF: bus finishes, no ready, next fetch works
        ack_delay = 1;
        exp_ram.push_back('{1'b0, 32'h300, 32'h0});
        @(posedge clk_i); #1;
        if_req_i = 1'b1; if_addr_i = 32'h300;
        wait_ram_req();
        @(posedge clk_i); #1;
        if_flush_i = 1'b1; if_req_i = 1'b0;
        @(posedge clk_i); #1;
        if_flush_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("flush_bus_done", 32'(ram_req_o), 0);
        chk("flush_ram_consumed", 32'(exp_ram.size()), 0);
        exp_ram.push_back('{1'b0, 32'h304, 32'h0});
        exp_if.push_back('{1'b1, 32'hC0DE_0304});
        @(posedge clk_i); #1;
        if_access(32'h304, lat);
        // Store
        exp_ram.push_back('{1'b1, 32'h4, 32'h5});
        exp_mem.push_back('{1'b0, 32'h0});
        @(posedge clk_i); #1;
        mem_access(1'b1, 32'h4, 32'h5);
        // Timeout: err_o rises after exactly 64 cycles waiting
        hold = 1'b1;
        exp_ram.push_back('{1'b0, 32'h80, 32'h0});
        exp_mem.push_back('{1'b1, 32'hC0DE_0080});
        @(posedge clk_i); #1;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h80;
        wait_ram_req();
        repeat (63) @(negedge clk_i);
        chk("err_before_timeout", 32'(err_o), 0);
        @(negedge clk_i);
        chk("err_at_timeout", 32'(err_o), 1);
        chk("ram_req_held", 32'(ram_req_o), 1);
        hold = 1'b0;
        begin
            int n = 0;
            do begin @(negedge clk_i); n++; end while (!mem_ready_o && n < 20);
            if (!mem_ready_o) chk("mem_ready_timeout", 0, 1);
        end
        @(posedge clk_i); #1;
        mem_req_i = 1'b0;
        @(negedge clk_i);
        chk("err_sticky", 32'(err_o), 1);
        // Reset mid-access
        hold = 1'b1;
        @(posedge clk_i); #1;
        mem_req_i = 1'b1; mem_addr_i = 32'h90;
        wait_ram_req();
        @(posedge clk_i); #3;
        rst_i = 1'b1;
        #1;
        chk("midrst_ram_req", 32'(ram_req_o), 0);
        chk("midrst_ram_addr", ram_addr_o, 0);
        chk("midrst_mem_ready", 32'(mem_ready_o), 0);
        chk("midrst_err", 32'(err_o), 0);
        mem_req_i = 1'b0; hold = 1'b0;
        repeat (2) @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("ram_q_empty", 32'(exp_ram.size()), 0);
        chk("if_q_empty", 32'(exp_if.size()), 0);
        chk("mem_q_empty", 32'(exp_mem.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
